// File: rtl/wb_pkg.sv
// Shared writeback-bus types and widths for the functional-unit result interface.
package wb_pkg;
    localparam int XLEN    = 32;
    localparam int ROBID_W = 7;
    localparam int RD_W    = 6;
    localparam int EC_W    = 5;

    localparam int SRC_SCALU = 0;
    localparam int SRC_IMUL  = 1;
    localparam int SRC_LSQ   = 2;
    localparam int SRC_BR    = 3;

    typedef struct packed {
        logic               error;
        logic [EC_W-1:0]    ecause;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [XLEN-1:0]    result;
    } wb_bus_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, searched cyclically.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // Doubling the request vector turns the cyclic search into a plain
    // lowest-set-bit search over bits >= ptr.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*N; j++) masked[j] = dbl[j] && (j >= int'(ptr));
        any   = |req;
        idx   = '0;
        grant = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (masked[j]) idx = IW'(j % N);
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one valid FU result round-robin into a one-entry
// output register, stalling every valid source that was not picked.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC-1:0]         src_error,
    input  logic [NSRC*EC_W-1:0]    src_ecause,
    input  logic [NSRC*ROBID_W-1:0] src_robid,
    input  logic [NSRC*RD_W-1:0]    src_rd,
    input  logic [NSRC*XLEN-1:0]    src_result,
    output logic [NSRC-1:0]         wb_src_stall,
    output logic                    wb_valid,
    output logic                    wb_error,
    output logic [EC_W-1:0]         wb_ecause,
    output logic [ROBID_W-1:0]      wb_robid,
    output logic [RD_W-1:0]         wb_rd,
    output logic [XLEN-1:0]         wb_result,
    output logic [SW-1:0]           wb_src,
    input  logic                    rob_wb_stall,
    input  logic                    rob_flush
);
    wb_bus_t         src_bus [NSRC];
    wb_bus_t         wb_q;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   gidx;
    logic            gany;
    logic            accept;

    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign src_bus[i] = '{
            error:  src_error[i],
            ecause: src_ecause[i*EC_W +: EC_W],
            robid:  src_robid[i*ROBID_W +: ROBID_W],
            rd:     src_rd[i*RD_W +: RD_W],
            result: src_result[i*XLEN +: XLEN]
        };
    end

    assign accept = ~wb_valid | ~rob_wb_stall;
    // Masking requests (reset, back-pressure, flush) leaves grant empty, so
    // stall then equals src_valid without any extra muxing.
    assign req          = (rst && accept && !rob_flush) ? src_valid : '0;
    assign wb_src_stall = src_valid & ~grant;

    rr_arbiter #(.N(NSRC), .IW(SW)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_q     <= '0;
            wb_src   <= '0;
            rr_ptr   <= '0;
        end else if (rob_flush) begin
            wb_valid <= 1'b0;
        end else if (accept) begin
            wb_valid <= gany;
            if (gany) begin
                wb_q   <= src_bus[gidx];
                wb_src <= gidx;
                rr_ptr <= (gidx == SW'(NSRC-1)) ? '0 : gidx + SW'(1);
            end
        end
    end

    assign wb_error  = wb_q.error;
    assign wb_ecause = wb_q.ecause;
    assign wb_robid  = wb_q.robid;
    assign wb_rd     = wb_q.rd;
    assign wb_result = wb_q.result;

    a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst)
        (wb_valid && rob_wb_stall && !rob_flush) |=> (wb_valid && $stable(wb_q) && $stable(wb_src)));
endmodule

// File: tb/tb_wb_arbiter.sv
// Table-driven bench for wb_arbiter with a scoreboard of expected broadcasts.
module tb_wb_arbiter;
    import wb_pkg::*;
    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         src_valid, src_error, wb_src_stall;
    logic [N*EC_W-1:0]    src_ecause;
    logic [N*ROBID_W-1:0] src_robid;
    logic [N*RD_W-1:0]    src_rd;
    logic [N*XLEN-1:0]    src_result;
    logic                 wb_valid, wb_error, rob_wb_stall, rob_flush;
    logic [EC_W-1:0]      wb_ecause;
    logic [ROBID_W-1:0]   wb_robid;
    logic [RD_W-1:0]      wb_rd;
    logic [XLEN-1:0]      wb_result;
    logic [1:0]           wb_src;

    wb_arbiter #(.NSRC(N)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_error(src_error),
        .src_ecause(src_ecause), .src_robid(src_robid), .src_rd(src_rd),
        .src_result(src_result), .wb_src_stall(wb_src_stall), .wb_valid(wb_valid),
        .wb_error(wb_error), .wb_ecause(wb_ecause), .wb_robid(wb_robid), .wb_rd(wb_rd),
        .wb_result(wb_result), .wb_src(wb_src), .rob_wb_stall(rob_wb_stall),
        .rob_flush(rob_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rs;
        logic       fl;
        logic [3:0] stl;
        int         gnt;
        logic       wbv;
    } vec_t;

    vec_t    tv [19];
    int      tests = 0;
    int      fails = 0;
    wb_bus_t exp_q [$];
    int      src_q [$];
    wb_bus_t last_bus;
    int      last_src;

    function automatic wb_bus_t mk(int i, int k);
        wb_bus_t b;
        b.error  = (i == 2) && (k % 2 == 1);
        b.ecause = 5'(k + i);
        b.robid  = 7'(i * 32 + k);
        b.rd     = 6'(k * 4 + i);
        b.result = 32'hA500_0000 ^ 32'(k << 8) ^ 32'(i);
        return b;
    endfunction

    task automatic set_src(input int i, input wb_bus_t b);
        src_error[i]                  = b.error;
        src_ecause[i*EC_W +: EC_W]    = b.ecause;
        src_robid[i*ROBID_W +: ROBID_W] = b.robid;
        src_rd[i*RD_W +: RD_W]        = b.rd;
        src_result[i*XLEN +: XLEN]    = b.result;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input wb_bus_t e, input int s);
        chk({nm, ".error"},  64'(wb_error),  64'(e.error));
        chk({nm, ".ecause"}, 64'(wb_ecause), 64'(e.ecause));
        chk({nm, ".robid"},  64'(wb_robid),  64'(e.robid));
        chk({nm, ".rd"},     64'(wb_rd),     64'(e.rd));
        chk({nm, ".result"}, 64'(wb_result), 64'(e.result));
        chk({nm, ".src"},    64'(wb_src),    64'(s));
    endtask

    initial begin
        //        v        rs    fl    stall    gnt wbv
        tv[0]  = '{4'b1111, 1'b0, 1'b0, 4'b1110,  0, 1'b1};
        tv[1]  = '{4'b1111, 1'b0, 1'b0, 4'b1101,  1, 1'b1};
        tv[2]  = '{4'b1111, 1'b0, 1'b0, 4'b1011,  2, 1'b1};
        tv[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0111,  3, 1'b1};
        tv[4]  = '{4'b1111, 1'b0, 1'b0, 4'b1110,  0, 1'b1};
        tv[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, -1, 1'b0};
        tv[6]  = '{4'b0001, 1'b0, 1'b0, 4'b0000,  0, 1'b1};
        tv[7]  = '{4'b0110, 1'b1, 1'b0, 4'b0110, -1, 1'b1};
        tv[8]  = '{4'b0110, 1'b1, 1'b0, 4'b0110, -1, 1'b1};
        tv[9]  = '{4'b0110, 1'b1, 1'b0, 4'b0110, -1, 1'b1};
        tv[10] = '{4'b0110, 1'b0, 1'b0, 4'b0100,  1, 1'b1};
        tv[11] = '{4'b0100, 1'b0, 1'b0, 4'b0000,  2, 1'b1};
        tv[12] = '{4'b0001, 1'b0, 1'b1, 4'b0001, -1, 1'b0};
        tv[13] = '{4'b1001, 1'b0, 1'b0, 4'b0001,  3, 1'b1};
        tv[14] = '{4'b1001, 1'b1, 1'b1, 4'b1001, -1, 1'b0};
        tv[15] = '{4'b1001, 1'b1, 1'b0, 4'b1000,  0, 1'b1};
        tv[16] = '{4'b1010, 1'b0, 1'b0, 4'b1000,  1, 1'b1};
        tv[17] = '{4'b1000, 1'b0, 1'b0, 4'b0000,  3, 1'b1};
        tv[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, -1, 1'b0};

        rst = 1'b0; src_valid = '0; src_error = '0; src_ecause = '0; src_robid = '0;
        src_rd = '0; src_result = '0; rob_wb_stall = 1'b0; rob_flush = 1'b0;
        last_bus = '0; last_src = 0;
        repeat (2) @(negedge clk);
        chk("reset.wb_valid",  64'(wb_valid),  64'd0);
        chk("reset.wb_result", 64'(wb_result), 64'd0);
        chk("reset.wb_src",    64'(wb_src),    64'd0);
        rst = 1'b1;

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            src_valid = tv[k].v; rob_wb_stall = tv[k].rs; rob_flush = tv[k].fl;
            for (int i = 0; i < N; i++) set_src(i, mk(i, k));
            if (tv[k].gnt >= 0) begin
                exp_q.push_back(mk(tv[k].gnt, k));
                src_q.push_back(tv[k].gnt);
            end
            #1 chk($sformatf("vec%0d.stall", k), 64'(wb_src_stall), 64'(tv[k].stl));
            @(posedge clk); #1;
            chk($sformatf("vec%0d.wb_valid", k), 64'(wb_valid), 64'(tv[k].wbv));
            if (tv[k].gnt >= 0) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("vec%0d.scoreboard", k), 64'd0, 64'd1);
                end else begin
                    last_bus = exp_q.pop_front();
                    last_src = src_q.pop_front();
                    chk_bus($sformatf("vec%0d", k), last_bus, last_src);
                end
            end else if (tv[k].wbv) begin
                chk_bus($sformatf("vec%0d.hold", k), last_bus, last_src);
            end
        end
        rob_wb_stall = 1'b0; rob_flush = 1'b0;

        // single scalu result with fixed fields
        @(negedge clk);
        src_valid = 4'b0001;
        set_src(0, '{error: 1'b0, ecause: 5'd0, robid: 7'h12, rd: 6'h05, result: 32'hDEADBEEF});
        #1 chk("single.stall", 64'(wb_src_stall), 64'd0);
        @(posedge clk); #1;
        chk("single.wb_valid", 64'(wb_valid), 64'd1);
        chk_bus("single", '{error: 1'b0, ecause: 5'd0, robid: 7'h12, rd: 6'h05, result: 32'hDEADBEEF}, 0);

        // error result from lsq passes through untouched
        @(negedge clk);
        src_valid = 4'b0100;
        set_src(2, '{error: 1'b1, ecause: 5'd4, robid: 7'h33, rd: 6'h21, result: 32'h0BAD_F00D});
        @(posedge clk); #1;
        chk("err.wb_valid", 64'(wb_valid), 64'd1);
        chk_bus("err", '{error: 1'b1, ecause: 5'd4, robid: 7'h33, rd: 6'h21, result: 32'h0BAD_F00D}, 2);

        // async reset in the middle of a held broadcast
        @(negedge clk);
        src_valid = 4'b0001; rob_wb_stall = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("areset.wb_valid", 64'(wb_valid),     64'd0);
        chk("areset.wb_error", 64'(wb_error),     64'd0);
        chk("areset.wb_ecause",64'(wb_ecause),    64'd0);
        chk("areset.wb_robid", 64'(wb_robid),     64'd0);
        chk("areset.wb_rd",    64'(wb_rd),        64'd0);
        chk("areset.wb_result",64'(wb_result),    64'd0);
        chk("areset.wb_src",   64'(wb_src),       64'd0);
        chk("areset.stall",    64'(wb_src_stall), 64'b0001);
        @(negedge clk);
        rst = 1'b1; rob_wb_stall = 1'b0; src_valid = 4'b0001;
        set_src(0, mk(0, 40));
        @(posedge clk); #1;
        chk("post_reset.wb_valid", 64'(wb_valid), 64'd1);
        chk_bus("post_reset", mk(0, 40), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
